// File: rtl/ping_pong_ctrl_w_if.sv
// Producer/consumer handshake bundle for the WEST ping-pong controller.
// master = controller side, slave = producer/consumer environment side.
interface ping_pong_ctrl_w_if #(
    parameter int MODULE_WIDTH = 64
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [MODULE_WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/ping_pong_ctrl_w.sv
// Purpose: fills two ping-pong banks from producer beats, replays each NUM_PASSES times, then frees it.
// Latency: bank writes in the accept cycle; out_valid follows a read issue by one cycle (RAM latency 1).
// Backpressure: in_ready drops while the target bank is occupied; reads stall while out_valid && !out_ready.
module ping_pong_ctrl_w #(
    parameter int MODULE_WIDTH  = 64,
    parameter int TOTAL_MODULES = 4,
    parameter int COL_X         = 16,
    parameter int TOTAL_INPUT_W = 2,
    parameter int NUM_PASSES    = 2,
    localparam int TOTAL_DEPTH  = COL_X * TOTAL_INPUT_W,
    localparam int ADDR_WIDTH   = $clog2(TOTAL_DEPTH),
    localparam int SLICE_W      = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ping_pong_ctrl_w_if.master      io,
    output logic [SLICE_W-1:0]      slicing_idx,
    output logic                    bank0_ena,
    output logic                    bank0_enb,
    output logic                    bank0_wea,
    output logic                    bank0_web,
    output logic [ADDR_WIDTH-1:0]   bank0_addra,
    output logic [ADDR_WIDTH-1:0]   bank0_addrb,
    input  logic [MODULE_WIDTH-1:0] bank0_douta,
    output logic                    bank1_ena,
    output logic                    bank1_enb,
    output logic                    bank1_wea,
    output logic                    bank1_web,
    output logic [ADDR_WIDTH-1:0]   bank1_addra,
    output logic [ADDR_WIDTH-1:0]   bank1_addrb,
    input  logic [MODULE_WIDTH-1:0] bank1_douta,
    output logic [1:0]              bank_full
);
    localparam int CNT_W  = (COL_X > 1) ? $clog2(COL_X) : 1;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_DRAINING
    } bank_st_t;

    bank_st_t               st [2];
    logic                   wr_bank;
    logic                   rd_bank;
    logic [CNT_W-1:0]       wr_cnt;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [PASS_W-1:0]      pass_cnt;
    logic                   rd_done;
    logic                   out_valid_q;
    logic                   out_last_q;

    logic                   wr_fire;
    logic                   wr_final;
    logic                   rd_issue;
    logic                   rd_wrap;
    logic                   rd_final;
    logic                   rd_free;

    logic [1:0]             ena;
    logic [1:0]             enb;
    logic [1:0]             wea;
    logic [1:0]             web;
    logic [ADDR_WIDTH-1:0]  addra [2];
    logic [ADDR_WIDTH-1:0]  addrb [2];

    // Writer only ever targets an EMPTY/FILLING bank and the reader only a FULL/DRAINING one,
    // so the two sides can never land on the same bank in one cycle.
    assign io.in_ready = !rst && (st[wr_bank] == ST_EMPTY || st[wr_bank] == ST_FILLING);
    assign wr_fire     = io.in_valid && io.in_ready;
    assign wr_final    = (wr_cnt == CNT_W'(COL_X - 1));

    // rd_done blocks issue between the final read and its acceptance.
    assign rd_issue = !rst && !rd_done
                      && (st[rd_bank] == ST_FULL || st[rd_bank] == ST_DRAINING)
                      && (!out_valid_q || io.out_ready);
    assign rd_wrap  = (rd_addr == ADDR_WIDTH'(TOTAL_DEPTH - 1));
    assign rd_final = rd_wrap && (pass_cnt == PASS_W'(NUM_PASSES - 1));
    assign rd_free  = out_valid_q && io.out_ready && out_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st[0]       <= ST_EMPTY;
            st[1]       <= ST_EMPTY;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_addr     <= '0;
            pass_cnt    <= '0;
            rd_done     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            slicing_idx <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_final) begin
                    st[wr_bank] <= ST_FULL;
                    wr_bank     <= ~wr_bank;
                    wr_cnt      <= '0;
                    slicing_idx <= (slicing_idx == SLICE_W'(TOTAL_MODULES - 1))
                                   ? '0 : slicing_idx + 1'b1;
                end else begin
                    st[wr_bank] <= ST_FILLING;
                    wr_cnt      <= wr_cnt + 1'b1;
                end
            end

            if (rd_issue) begin
                st[rd_bank] <= ST_DRAINING;
                out_valid_q <= 1'b1;
                out_last_q  <= rd_final;
                if (rd_wrap) begin
                    rd_addr <= '0;
                    if (rd_final) begin
                        pass_cnt <= '0;
                        rd_done  <= 1'b1;
                    end else begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end else if (io.out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            if (rd_free) begin
                st[rd_bank] <= ST_EMPTY;
                rd_bank     <= ~rd_bank;
                rd_done     <= 1'b0;
                rd_addr     <= '0;
                pass_cnt    <= '0;
            end
        end
    end

    always_comb begin
        ena      = '0;
        enb      = '0;
        wea      = '0;
        web      = '0;
        addra[0] = '0;
        addra[1] = '0;
        addrb[0] = '0;
        addrb[1] = '0;
        if (wr_fire) begin
            ena[wr_bank]   = 1'b1;
            enb[wr_bank]   = 1'b1;
            wea[wr_bank]   = 1'b1;
            web[wr_bank]   = 1'b1;
            addra[wr_bank] = ADDR_WIDTH'(wr_cnt);
            addrb[wr_bank] = ADDR_WIDTH'(COL_X) + ADDR_WIDTH'(wr_cnt);
        end
        if (rd_issue) begin
            ena[rd_bank]   = 1'b1;
            addra[rd_bank] = rd_addr;
        end
    end

    assign bank0_ena   = ena[0];
    assign bank0_enb   = enb[0];
    assign bank0_wea   = wea[0];
    assign bank0_web   = web[0];
    assign bank0_addra = addra[0];
    assign bank0_addrb = addrb[0];
    assign bank1_ena   = ena[1];
    assign bank1_enb   = enb[1];
    assign bank1_wea   = wea[1];
    assign bank1_web   = web[1];
    assign bank1_addra = addra[1];
    assign bank1_addrb = addrb[1];

    // RAM output holds while ena is low, so a stalled word stays on out_data.
    assign io.out_valid = out_valid_q;
    assign io.out_last  = out_valid_q && out_last_q;
    assign io.out_data  = out_valid_q ? (rd_bank ? bank1_douta : bank0_douta) : '0;

    assign bank_full[0] = (st[0] == ST_FULL) || (st[0] == ST_DRAINING);
    assign bank_full[1] = (st[1] == ST_FULL) || (st[1] == ST_DRAINING);
endmodule

// File: tb/tb_ping_pong_ctrl_w.sv
// Directed bench for ping_pong_ctrl_w (COL_X=4, NUM_PASSES=2) with two behavioural banks
// and an in-order scoreboard of expected read words.
module tb_ping_pong_ctrl_w;
    localparam int MW = 16;
    localparam int CX = 4;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic [1:0]    slicing_idx;
    logic          bank0_ena, bank0_enb, bank0_wea, bank0_web;
    logic          bank1_ena, bank1_enb, bank1_wea, bank1_web;
    logic [AW-1:0] bank0_addra, bank0_addrb, bank1_addra, bank1_addrb;
    logic [MW-1:0] bank0_douta, bank1_douta;
    logic [1:0]    bank_full;
    logic [MW-1:0] din_a, din_b;
    logic [MW-1:0] mem0 [8];
    logic [MW-1:0] mem1 [8];

    ping_pong_ctrl_w_if #(.MODULE_WIDTH(MW)) pif ();

    ping_pong_ctrl_w #(
        .MODULE_WIDTH (MW),
        .TOTAL_MODULES(4),
        .COL_X        (CX),
        .TOTAL_INPUT_W(2),
        .NUM_PASSES   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (pif),
        .slicing_idx(slicing_idx),
        .bank0_ena  (bank0_ena),
        .bank0_enb  (bank0_enb),
        .bank0_wea  (bank0_wea),
        .bank0_web  (bank0_web),
        .bank0_addra(bank0_addra),
        .bank0_addrb(bank0_addrb),
        .bank0_douta(bank0_douta),
        .bank1_ena  (bank1_ena),
        .bank1_enb  (bank1_enb),
        .bank1_wea  (bank1_wea),
        .bank1_web  (bank1_web),
        .bank1_addra(bank1_addra),
        .bank1_addrb(bank1_addrb),
        .bank1_douta(bank1_douta),
        .bank_full  (bank_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank0_ena && bank0_wea) mem0[bank0_addra] <= din_a;
        if (bank0_enb && bank0_web) mem0[bank0_addrb] <= din_b;
        if (bank0_ena && !bank0_wea) bank0_douta <= mem0[bank0_addra];
        if (bank1_ena && bank1_wea) mem1[bank1_addra] <= din_a;
        if (bank1_enb && bank1_web) mem1[bank1_addrb] <= din_b;
        if (bank1_ena && !bank1_wea) bank1_douta <= mem1[bank1_addra];
    end

    typedef struct packed {
        logic [MW-1:0] d;
        logic          last;
    } exp_t;

    exp_t          exp_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            beat_k  = 0;
    int            fills   = 0;
    int            tag     = 0;
    int            n_last  = 0;
    int            last_acc_cyc = -100;
    logic          held    = 1'b0;
    logic [MW-1:0] held_d  = '0;

    function automatic logic [MW-1:0] word(input int t, input int a);
        return MW'(32'h1000 + t * 16 + a);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy);
        pif.in_valid  = iv;
        pif.out_ready = ordy;
        din_a = word(tag, beat_k);
        din_b = word(tag, CX + beat_k);
        #1;
    endtask

    // Scores this cycle's write beat and output word, then advances to the next negedge.
    task automatic observe();
        if (pif.in_valid && pif.in_ready) begin
            chk("wr_slice", 32'(slicing_idx), 32'(fills % 4));
            if (fills % 2 == 0) begin
                chk("wr_ports_b0", 32'({bank0_ena, bank0_enb, bank0_wea, bank0_web}), 32'hF);
                chk("wr_addra_b0", 32'(bank0_addra), 32'(beat_k));
                chk("wr_addrb_b0", 32'(bank0_addrb), 32'(CX + beat_k));
                chk("wr_other_b1", 32'({bank1_wea, bank1_web}), 32'h0);
            end else begin
                chk("wr_ports_b1", 32'({bank1_ena, bank1_enb, bank1_wea, bank1_web}), 32'hF);
                chk("wr_addra_b1", 32'(bank1_addra), 32'(beat_k));
                chk("wr_addrb_b1", 32'(bank1_addrb), 32'(CX + beat_k));
                chk("wr_other_b0", 32'({bank0_wea, bank0_web}), 32'h0);
            end
            beat_k++;
            if (beat_k == CX) begin
                for (int p = 0; p < 2; p++)
                    for (int a = 0; a < 2 * CX; a++)
                        exp_q.push_back('{d: word(tag, a), last: (p == 1 && a == 2 * CX - 1)});
                beat_k = 0;
                fills++;
                tag++;
            end
        end
        if (pif.out_valid) begin
            if (held) chk("stall_stable", 32'(pif.out_data), 32'(held_d));
            if (pif.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 32'(pif.out_valid), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(pif.out_data), 32'(e.d));
                    chk("rd_last", 32'(pif.out_last), 32'(e.last));
                    if (e.last) begin
                        last_acc_cyc = cyc;
                        n_last++;
                    end
                end
                held = 1'b0;
            end else begin
                held   = 1'b1;
                held_d = pif.out_data;
            end
        end else begin
            held = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        pif.in_valid  = 1'b0;
        pif.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        cyc++;
        chk("rst_in_ready", 32'(pif.in_ready), 32'h0);
        chk("rst_out_valid", 32'(pif.out_valid), 32'h0);
        chk("rst_out_last", 32'(pif.out_last), 32'h0);
        chk("rst_out_data", 32'(pif.out_data), 32'h0);
        chk("rst_bank_full", 32'(bank_full), 32'h0);
        chk("rst_slicing_idx", 32'(slicing_idx), 32'h0);
        chk("rst_bank_en", 32'({bank0_ena, bank0_enb, bank0_wea, bank0_web,
                                bank1_ena, bank1_enb, bank1_wea, bank1_web}), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(pif.in_ready), 32'h1);
        exp_q.delete();
        fills  = 0;
        beat_k = 0;
        held   = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int   i;
        int   n_rel;
        logic prev_stall;
        logic [31:0] pat;

        rst = 1'b1;
        pif.in_valid  = 1'b0;
        pif.out_ready = 1'b0;
        din_a = '0;
        din_b = '0;
        @(negedge clk);
        do_reset();

        // Single fill into bank0, then 16 streaming reads.
        for (int k = 0; k < CX; k++) begin
            drive(1'b1, 1'b1);
            if (k == 0) chk("fill1_b1_idle", 32'(bank1_ena), 32'h0);
            observe();
        end
        drive(1'b0, 1'b1);
        chk("issue_ena", 32'(bank0_ena), 32'h1);
        chk("issue_wea", 32'(bank0_wea), 32'h0);
        chk("issue_addra", 32'(bank0_addra), 32'h0);
        chk("issue_no_valid", 32'(pif.out_valid), 32'h0);
        chk("slice_after_fill1", 32'(slicing_idx), 32'h1);
        chk("full_after_fill1", 32'(bank_full), 32'h1);
        observe();
        for (i = 1; i <= 40; i++) begin
            drive(1'b0, 1'b1);
            observe();
            if (n_last == 1) break;
        end
        chk("drain1_cycles", 32'(i), 32'd16);
        drive(1'b0, 1'b1);
        chk("empty_after_drain1", 32'(bank_full), 32'h0);
        observe();

        // Continuous producer against an irregular consumer; fills 2..5 with slicing wrap.
        pat = 32'hB5C3_9A6D;
        prev_stall = 1'b0;
        n_rel = 0;
        for (i = 0; i < 800; i++) begin
            drive(fills < 5, pat[cyc % 32]);
            if (prev_stall && pif.in_ready) begin
                chk("ready_after_free", 32'(cyc - last_acc_cyc), 32'h1);
                n_rel++;
            end
            if (pif.in_valid && !pif.in_ready) chk("full_when_stalled", 32'(bank_full), 32'h3);
            prev_stall = pif.in_valid && !pif.in_ready;
            observe();
            if (fills >= 5 && exp_q.size() == 0 && !pif.out_valid) break;
        end
        chk("stream_drained", 32'(exp_q.size()), 32'h0);
        chk("stream_fills", 32'(fills), 32'd5);
        chk("stall_releases", 32'(n_rel), 32'd2);
        chk("slice_wrapped", 32'(slicing_idx), 32'h1);

        // Reset in the middle of a fill (bank1 half written).
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1);
            observe();
        end
        do_reset();

        // Fill after reset lands on bank0 at addr 0, slicing 0; then reset mid-drain.
        for (int k = 0; k < CX; k++) begin
            drive(1'b1, 1'b1);
            observe();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1);
            observe();
        end
        chk("mid_drain_valid", 32'(pif.out_valid), 32'h1);
        do_reset();

        // Clean fill and drain after the mid-drain reset.
        n_last = 0;
        for (int k = 0; k < CX; k++) begin
            drive(1'b1, 1'b1);
            observe();
        end
        for (i = 0; i < 60; i++) begin
            drive(1'b0, 1'b1);
            observe();
            if (n_last == 1) break;
        end
        chk("final_drain_done", 32'(n_last), 32'h1);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("final_slice", 32'(slicing_idx), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
